// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/RUN/HALTED sequencing, next-PC selection
// (register jump > jump > branch > sequential), trap capture and a wrapping
// count of accepted fetches.
module pc_fetch_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             exception,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             imem_req,
    output logic             fetch_fire,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_MIS = 2'b10;

    state_t                  state;
    logic signed [WIDTH-1:0] br_disp;
    logic        [WIDTH-1:0] branch_target;
    logic        [WIDTH-1:0] jump_target;
    logic        [WIDTH-1:0] next_pc;
    logic                    misaligned_jr;

    assign pc_plus4   = pc + WIDTH'(4);
    assign imem_req   = (state == RUN);
    assign halted     = (state == HALTED);
    assign fetch_fire = imem_req & imem_ready & ~stall;

    // Word offset sign-extended and scaled to bytes; WIDTH >= 28 keeps the fill count positive.
    assign br_disp       = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_target = pc_plus4 + $unsigned(br_disp);

    // A misaligned register target only matters when the jump is actually taken (fetch_fire).
    assign misaligned_jr = jump_reg & (reg_target[1:0] != 2'b00);

    // Jump keeps the region bits of pc+4 above bit 27 and replaces the low 28 bits.
    always_comb begin
        jump_target       = pc_plus4;
        jump_target[27:0] = {jump_index, 2'b00};
    end

    // Next-PC priority: register jump, then jump, then branch, then sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg)
            next_pc = reg_target;
        else if (jump)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = branch_target;
    end

    // State machine with PC, trap and fetch-count registers; traps win over halt and fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            epc         <= '0;
            cause       <= 2'b00;
            fetch_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (exception) begin
                        epc   <= pc;
                        pc    <= EXC_VECTOR;
                        cause <= CAUSE_EXT;
                    end else if (fetch_fire && misaligned_jr) begin
                        epc   <= pc;
                        pc    <= EXC_VECTOR;
                        cause <= CAUSE_MIS;
                    end else begin
                        if (fetch_fire) begin
                            pc          <= next_pc;
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                        if (halt)
                            state <= HALTED;
                    end
                end
                HALTED: begin
                    if (exception) begin
                        epc   <= pc;
                        pc    <= EXC_VECTOR;
                        cause <= CAUSE_EXT;
                        state <= RUN;
                    end else if (resume) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed stimulus pushes expected observations into
// a scoreboard tagged with the cycle they belong to; a negedge monitor pops and
// compares them against the DUT.
module tb_pc_fetch_unit;

    localparam int K_PC    = 0;
    localparam int K_PLUS4 = 1;
    localparam int K_REQ   = 2;
    localparam int K_FF    = 3;
    localparam int K_EPC   = 4;
    localparam int K_CAUSE = 5;
    localparam int K_CNT   = 6;
    localparam int K_HALT  = 7;
    localparam int K_CNT4  = 8;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, halt, resume, branch_taken, jump, jump_reg, exception, imem_ready;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] reg_target;

    logic [31:0] pc, pc_plus4, epc;
    logic        imem_req, fetch_fire, halted;
    logic [1:0]  cause;
    logic [15:0] fetch_count;

    logic [31:0] pc_b, pc_plus4_b, epc_b;
    logic        imem_req_b, fetch_fire_b, halted_b;
    logic [1:0]  cause_b;
    logic [3:0]  fetch_count_b;

    exp_t sb[$];
    exp_t e;
    int   cycle   = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
        .reg_target(reg_target), .exception(exception), .imem_ready(imem_ready),
        .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .fetch_fire(fetch_fire),
        .epc(epc), .cause(cause), .fetch_count(fetch_count), .halted(halted)
    );

    pc_fetch_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
        .reg_target(reg_target), .exception(exception), .imem_ready(imem_ready),
        .pc(pc_b), .pc_plus4(pc_plus4_b), .imem_req(imem_req_b), .fetch_fire(fetch_fire_b),
        .epc(epc_b), .cause(cause_b), .fetch_count(fetch_count_b), .halted(halted_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [63:0] actual(input int kind);
        case (kind)
            K_PC:    return 64'(pc);
            K_PLUS4: return 64'(pc_plus4);
            K_REQ:   return 64'(imem_req);
            K_FF:    return 64'(fetch_fire);
            K_EPC:   return 64'(epc);
            K_CAUSE: return 64'(cause);
            K_CNT:   return 64'(fetch_count);
            K_HALT:  return 64'(halted);
            K_CNT4:  return 64'(fetch_count_b);
            default: return '1;
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cycle) begin
                errors++;
                $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cycle);
            end else if (actual(e.kind) !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, actual(e.kind), e.val);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string name, input int kind, input logic [63:0] val);
        exp_t x;
        x.cyc  = cycle;
        x.name = name;
        x.kind = kind;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic tick(input int fires);
        @(posedge clk);
        #1;
        exp_cnt += fires;
    endtask

    task automatic clr();
        stall = 0; halt = 0; resume = 0; exception = 0;
        branch_taken = 0; branch_offset = '0;
        jump = 0; jump_index = '0; jump_reg = 0; reg_target = '0;
    endtask

    // Steer the PC to an aligned address with a register jump (needs RUN).
    task automatic goto_pc(input logic [31:0] a);
        clr();
        imem_ready = 1;
        jump_reg   = 1;
        reg_target = a;
        tick(1);
        clr();
    endtask

    initial begin
        clr();
        reset = 1;
        imem_ready = 0;
        tick(0);
        tick(0);

        // Reset state
        imem_ready = 1;
        expect_val("rst_pc", K_PC, 0);
        expect_val("rst_req", K_REQ, 0);
        expect_val("rst_halt", K_HALT, 0);
        expect_val("rst_cause", K_CAUSE, 0);
        expect_val("rst_epc", K_EPC, 0);
        expect_val("rst_cnt", K_CNT, 0);
        tick(0);

        // Single BOOT cycle, then sequential fetch
        reset = 0;
        expect_val("boot_req", K_REQ, 0);
        expect_val("boot_ff", K_FF, 0);
        tick(0);
        expect_val("run_req", K_REQ, 1);
        expect_val("run_pc0", K_PC, 0);
        expect_val("run_ff", K_FF, 1);
        tick(1);
        expect_val("seq_pc4", K_PC, 4);
        tick(1);
        expect_val("seq_pc8", K_PC, 8);
        tick(1);
        expect_val("seq_pc12", K_PC, 12);
        expect_val("seq_cnt3", K_CNT, 3);
        expect_val("seq_plus4", K_PLUS4, 16);

        // Branch backwards
        goto_pc(32'h100);
        branch_taken = 1; branch_offset = 16'hFFFE;
        tick(1); clr();
        expect_val("branch_back", K_PC, 32'hFC);

        // Jumps
        goto_pc(32'h100);
        jump = 1; jump_index = 26'h40;
        tick(1); clr();
        expect_val("jump_0x40", K_PC, 32'h100);
        goto_pc(32'h1000_0000);
        jump = 1; jump_index = 26'h40;
        tick(1); clr();
        expect_val("jump_region", K_PC, 32'h1000_0100);
        goto_pc(32'h100);
        jump_reg = 1; reg_target = 32'h300; jump = 1; jump_index = 26'h40; branch_taken = 1;
        tick(1); clr();
        expect_val("jr_priority", K_PC, 32'h300);

        // Stall holds PC and ignores redirects
        goto_pc(32'h20);
        stall = 1; branch_taken = 1; branch_offset = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            expect_val("stall_ff", K_FF, 0);
            tick(0);
            expect_val("stall_pc", K_PC, 32'h20);
        end
        expect_val("stall_cnt", K_CNT, 64'(exp_cnt));
        stall = 0;
        expect_val("unstall_ff", K_FF, 1);
        tick(1); clr();
        expect_val("unstall_branch", K_PC, 32'h34);
        expect_val("unstall_cnt", K_CNT, 64'(exp_cnt));

        // Not-ready holds the same way
        goto_pc(32'h20);
        imem_ready = 0; branch_taken = 1; branch_offset = 16'h0004;
        for (int i = 0; i < 2; i++) begin
            expect_val("nrdy_ff", K_FF, 0);
            expect_val("nrdy_req", K_REQ, 1);
            tick(0);
            expect_val("nrdy_pc", K_PC, 32'h20);
        end
        imem_ready = 1;
        tick(1); clr();
        expect_val("rdy_branch", K_PC, 32'h34);

        // Misaligned register jump trap
        goto_pc(32'h40);
        jump_reg = 1; reg_target = 32'h202;
        tick(0); clr();
        expect_val("mis_pc", K_PC, 32'h180);
        expect_val("mis_epc", K_EPC, 32'h40);
        expect_val("mis_cause", K_CAUSE, 2);
        expect_val("mis_cnt", K_CNT, 64'(exp_cnt));
        expect_val("mis_req", K_REQ, 1);
        tick(1);
        expect_val("hold_cause", K_CAUSE, 2);
        expect_val("hold_epc", K_EPC, 32'h40);
        expect_val("after_trap_pc", K_PC, 32'h184);

        // External exception during stall
        stall = 1; exception = 1;
        tick(0); clr();
        expect_val("exc_pc", K_PC, 32'h180);
        expect_val("exc_epc", K_EPC, 32'h184);
        expect_val("exc_cause", K_CAUSE, 1);
        expect_val("exc_cnt", K_CNT, 64'(exp_cnt));

        // Exception beats misaligned jump_reg
        tick(1);
        jump_reg = 1; reg_target = 32'h202; exception = 1;
        tick(0); clr();
        expect_val("both_cause", K_CAUSE, 1);
        expect_val("both_epc", K_EPC, 32'h184);

        // Trap beats halt
        halt = 1; exception = 1;
        tick(0); clr();
        expect_val("trap_vs_halt_h", K_HALT, 0);
        expect_val("trap_vs_halt_epc", K_EPC, 32'h180);

        // Halt with fetch in the same cycle, then resume
        goto_pc(32'h10);
        halt = 1;
        tick(1); clr();
        expect_val("halt_pc", K_PC, 32'h14);
        expect_val("halt_flag", K_HALT, 1);
        expect_val("halt_req", K_REQ, 0);
        expect_val("halt_ff", K_FF, 0);
        branch_taken = 1; branch_offset = 16'h0040;
        tick(0);
        expect_val("halted_hold", K_PC, 32'h14);
        resume = 1;
        tick(0); clr();
        expect_val("resume_halt", K_HALT, 0);
        expect_val("resume_req", K_REQ, 1);
        expect_val("resume_pc", K_PC, 32'h14);
        tick(1);
        expect_val("resume_next", K_PC, 32'h18);

        // Exception beats resume in HALTED
        halt = 1;
        tick(1); clr();
        expect_val("halt2_pc", K_PC, 32'h1C);
        exception = 1; resume = 1;
        tick(0); clr();
        expect_val("hexc_pc", K_PC, 32'h180);
        expect_val("hexc_epc", K_EPC, 32'h1C);
        expect_val("hexc_cause", K_CAUSE, 1);
        expect_val("hexc_halt", K_HALT, 0);

        // PC wraps
        goto_pc(32'hFFFF_FFFC);
        expect_val("wrap_plus4", K_PLUS4, 0);
        tick(1);
        expect_val("wrap_pc", K_PC, 0);

        // Reset during stall with competing inputs
        stall = 1; branch_taken = 1; halt = 1; exception = 1; reset = 1;
        tick(0); clr();
        exp_cnt = 0;
        expect_val("rst2_pc", K_PC, 0);
        expect_val("rst2_epc", K_EPC, 0);
        expect_val("rst2_cause", K_CAUSE, 0);
        expect_val("rst2_cnt", K_CNT, 0);
        expect_val("rst2_req", K_REQ, 0);
        expect_val("rst2_halt", K_HALT, 0);

        // 17 fetches: 4-bit counter wraps to 1
        reset = 0; imem_ready = 1;
        tick(0);
        for (int i = 0; i < 17; i++) tick(1);
        expect_val("cnt17", K_CNT, 64'(exp_cnt));
        expect_val("cnt4_wrap", K_CNT4, 1);
        expect_val("cnt17_pc", K_PC, 32'h44);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
